// File: rtl/vx_commit_retire.sv
// ---------------------------------------------------------------------------
// VxCommitRetire: commit-stage retire unit for one issue slot.
//
// Accepts commit beats from the gather output, forwards them one cycle later
// as register writebacks, tracks sop/eop packet framing per warp, counts
// retired instructions and flags framing violations.
//
// Ports:
//   clk, reset                  sole clock, synchronous active-high reset
//   commit_valid / commit_ready beat handshake (ready is simply !reset)
//   commit_uuid .. commit_eop   beat payload (uuid, warp id, thread mask, pc,
//                               writeback enable, rd, lane data, sop, eop)
//   wb_valid .. wb_eop          registered writeback port, no backpressure
//   instret                     64-bit count of retired (eop) beats
//   proto_err                   sticky sop/eop framing violation flag
//   warp_busy                   per-warp "multi-beat packet open" bit
// ---------------------------------------------------------------------------
module vx_commit_retire #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int UUID_WIDTH  = 1,
    localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        commit_valid,
    output logic                        commit_ready,
    input  logic [UUID_WIDTH-1:0]       commit_uuid,
    input  logic [WID_W-1:0]            commit_wid,
    input  logic [NUM_THREADS-1:0]      commit_tmask,
    input  logic [XLEN-1:0]             commit_pc,
    input  logic                        commit_wb,
    input  logic [NR_BITS-1:0]          commit_rd,
    input  logic [NUM_THREADS*XLEN-1:0] commit_data,
    input  logic                        commit_sop,
    input  logic                        commit_eop,

    output logic                        wb_valid,
    output logic [UUID_WIDTH-1:0]       wb_uuid,
    output logic [WID_W-1:0]            wb_wid,
    output logic [NUM_THREADS-1:0]      wb_tmask,
    output logic [NR_BITS-1:0]          wb_rd,
    output logic [NUM_THREADS*XLEN-1:0] wb_data,
    output logic                        wb_eop,

    output logic [63:0]                 instret,
    output logic                        proto_err,
    output logic [NUM_WARPS-1:0]        warp_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } warpState_e;

    warpState_e                  warpState_q [NUM_WARPS];
    logic                        wbValid_q;
    logic [UUID_WIDTH-1:0]       wbUuid_q;
    logic [WID_W-1:0]            wbWid_q;
    logic [NUM_THREADS-1:0]      wbTmask_q;
    logic [NR_BITS-1:0]          wbRd_q;
    logic [NUM_THREADS*XLEN-1:0] wbData_q;
    logic                        wbEop_q;
    logic [63:0]                 instret_q;
    logic [63:0]                 instret_d;
    logic                        protoErr_q;
    logic                        protoErr_d;

    logic                        fire;
    warpState_e                  curState;
    warpState_e                  nextState;
    logic                        framingErr;
    logic                        unusedPc;

    // The PC travels with the beat but the writeback port has no use for it.
    assign unusedPc = ^commit_pc;

    // Ready drops only during reset, so a beat fires whenever valid is high
    // outside reset.
    assign commit_ready = !reset;
    assign fire         = commit_valid && commit_ready;

    // Framing decision for the addressed warp. In every case the packet ends
    // up OPEN exactly when the beat is not an eop; an illegal sop just
    // restarts the packet, so only the error flag depends on the old state.
    always_comb begin
        curState = IDLE;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (WID_W'(w) == commit_wid) begin
                curState = warpState_q[w];
            end
        end
        nextState  = commit_eop ? IDLE : OPEN;
        framingErr = (curState == IDLE) ? !commit_sop : commit_sop;
        instret_d  = (fire && commit_eop) ? instret_q + 64'd1 : instret_q;
        protoErr_d = protoErr_q || (fire && framingErr);
    end

    // Main register block: writeback pipeline stage, per-warp packet FSMs,
    // retire counter and sticky error. Payload registers only load on a
    // fired beat so the last writeback stays visible while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbValid_q  <= 1'b0;
            wbUuid_q   <= '0;
            wbWid_q    <= '0;
            wbTmask_q  <= '0;
            wbRd_q     <= '0;
            wbData_q   <= '0;
            wbEop_q    <= 1'b0;
            instret_q  <= 64'd0;
            protoErr_q <= 1'b0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                warpState_q[w] <= IDLE;
            end
        end else begin
            wbValid_q  <= fire && commit_wb && (|commit_tmask);
            instret_q  <= instret_d;
            protoErr_q <= protoErr_d;
            if (fire) begin
                wbUuid_q  <= commit_uuid;
                wbWid_q   <= commit_wid;
                wbTmask_q <= commit_tmask;
                wbRd_q    <= commit_rd;
                wbData_q  <= commit_data;
                wbEop_q   <= commit_eop;
                for (int w = 0; w < NUM_WARPS; w++) begin
                    if (WID_W'(w) == commit_wid) begin
                        warpState_q[w] <= nextState;
                    end
                end
            end
        end
    end

    // Busy view of the per-warp FSMs.
    always_comb begin
        warp_busy = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_busy[w] = (warpState_q[w] == OPEN);
        end
    end

    assign wb_valid  = wbValid_q;
    assign wb_uuid   = wbUuid_q;
    assign wb_wid    = wbWid_q;
    assign wb_tmask  = wbTmask_q;
    assign wb_rd     = wbRd_q;
    assign wb_data   = wbData_q;
    assign wb_eop    = wbEop_q;
    assign instret   = instret_q;
    assign proto_err = protoErr_q;

endmodule
